// File: rtl/isolator_link_master.sv
// isolator_link_master
//
// Host-side end of the isolator-board serial control link. Each frame
// shifts one byte of chip-select data and one byte of hwcon data out to the
// board's shift registers while shifting the board's dir/chan and hwflag
// snapshot back in. The board latches the outgoing bytes and takes a new
// snapshot on the srclk strobe at the end of every frame. Frames run
// back to back while enable is high, so the per-slot status stays fresh.
//
// Frame timeline (D = SCLK_DIV, 1 + 18*D clk cycles in total):
//   LOAD  (1)     capture the transmit bytes
//   SHIFT (16*D)  8 sclk periods, sclk low for the first half of each bit
//   LATCH (D)     srclk high
//   GAP   (D)     srclk low; frame_done and slot_* update in the last cycle
//
// Ports
//   clk, reset           system clock, asynchronous active-high reset
//   enable               run frames continuously; low stops after the frame
//   cs_n_par[3:0]        per-slot chip selects (active low) to transmit
//   hwcon_par[3:0]       per-slot hwcon bits to transmit
//   sclk, srclk          serial shift clock and latch strobe to the board
//   cs_n, hwcon          serial transmit data, MSB first
//   dirchan, hwflag      serial receive data, MSB first
//   slot_dir/chan/hwflag decoded per-slot status
//   status_valid         slot_* holds data from a real board snapshot
//   frame_done           1-cycle pulse in the last cycle of every frame
//   status_changed       1-cycle pulse when a valid update alters slot_*
//   fsm_state            current FSM state, for observation only
//
// SCLK_DIV is the number of clk cycles per sclk half-period (2..255).

module isolator_link_master #(
    parameter int SCLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] cs_n_par,
    input  logic [3:0] hwcon_par,
    output logic       sclk,
    output logic       srclk,
    output logic       cs_n,
    output logic       hwcon,
    input  logic       dirchan,
    input  logic       hwflag,
    output logic [3:0] slot_dir,
    output logic [3:0] slot_chan,
    output logic [3:0] slot_hwflag,
    output logic       status_valid,
    output logic       frame_done,
    output logic       status_changed,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        LATCH = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);
    // The status registers are loaded one cycle early so that they become
    // visible in the same cycle as the frame_done pulse.
    localparam logic [7:0] DIV_PRE  = 8'(SCLK_DIV - 2);

    state_t     state, state_n;
    logic [7:0] div_cnt, div_n;
    logic [2:0] bit_cnt, bit_n;
    logic       sclk_n, srclk_n;
    logic [7:0] tx_cs, tx_cs_n;
    logic [7:0] tx_hw, tx_hw_n;
    logic [7:0] rx_dc, rx_dc_n;
    // Only the low nibble of the hwflag byte carries data; shifting the
    // whole byte through a 4-bit register leaves exactly that nibble.
    logic [3:0] rx_hf, rx_hf_n;
    // Set once the current run has completed a frame, so the next frame's
    // receive data belongs to a snapshot taken inside this run.
    logic       primed, primed_n;
    logic [3:0] dir_n, chan_n, hwf_n;
    logic       valid_n, done_n, changed_n;

    // The transmit shift registers drive the pins directly from bit 7.
    // Between frames tx_cs is all ones (cs_n idle high) and tx_hw keeps
    // the last bit sent.
    assign cs_n      = tx_cs[7];
    assign hwcon     = tx_hw[7];
    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            sclk           <= 1'b0;
            srclk          <= 1'b0;
            tx_cs          <= 8'hFF;
            tx_hw          <= 8'h00;
            rx_dc          <= 8'h00;
            rx_hf          <= 4'h0;
            primed         <= 1'b0;
            slot_dir       <= 4'h0;
            slot_chan      <= 4'h0;
            slot_hwflag    <= 4'h0;
            status_valid   <= 1'b0;
            frame_done     <= 1'b0;
            status_changed <= 1'b0;
        end else begin
            state          <= state_n;
            div_cnt        <= div_n;
            bit_cnt        <= bit_n;
            sclk           <= sclk_n;
            srclk          <= srclk_n;
            tx_cs          <= tx_cs_n;
            tx_hw          <= tx_hw_n;
            rx_dc          <= rx_dc_n;
            rx_hf          <= rx_hf_n;
            primed         <= primed_n;
            slot_dir       <= dir_n;
            slot_chan      <= chan_n;
            slot_hwflag    <= hwf_n;
            status_valid   <= valid_n;
            frame_done     <= done_n;
            status_changed <= changed_n;
        end
    end

    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        bit_n     = bit_cnt;
        sclk_n    = sclk;
        srclk_n   = srclk;
        tx_cs_n   = tx_cs;
        tx_hw_n   = tx_hw;
        rx_dc_n   = rx_dc;
        rx_hf_n   = rx_hf;
        primed_n  = primed;
        dir_n     = slot_dir;
        chan_n    = slot_chan;
        hwf_n     = slot_hwflag;
        valid_n   = status_valid;
        done_n    = 1'b0;
        changed_n = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = LOAD;
                end
            end

            LOAD: begin
                // Upper nibbles are padding: cs_n inactive, hwcon low.
                tx_cs_n = {4'hF, cs_n_par};
                tx_hw_n = {4'h0, hwcon_par};
                div_n   = '0;
                bit_n   = '0;
                sclk_n  = 1'b0;
                state_n = SHIFT;
            end

            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        // Falling edge: sample the bit the board launched on
                        // the preceding rising edge, and launch our next bit.
                        sclk_n  = 1'b0;
                        rx_dc_n = {rx_dc[6:0], dirchan};
                        rx_hf_n = {rx_hf[2:0], hwflag};
                        if (bit_cnt == 3'd7) begin
                            tx_cs_n = 8'hFF;
                            srclk_n = 1'b1;
                            state_n = LATCH;
                        end else begin
                            tx_cs_n = {tx_cs[6:0], 1'b1};
                            tx_hw_n = {tx_hw[6:0], 1'b0};
                            bit_n   = bit_cnt + 3'd1;
                        end
                    end
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end

            LATCH: begin
                if (div_cnt == DIV_LAST) begin
                    div_n   = '0;
                    srclk_n = 1'b0;
                    state_n = GAP;
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end

            GAP: begin
                if (div_cnt == DIV_PRE) begin
                    done_n   = 1'b1;
                    primed_n = 1'b1;
                    // The first frame of a run carries a snapshot taken
                    // before the run began; it is dropped.
                    if (primed) begin
                        dir_n     = rx_dc[3:0];
                        chan_n    = rx_dc[7:4];
                        hwf_n     = rx_hf;
                        valid_n   = 1'b1;
                        changed_n = status_valid &&
                                    ({rx_hf, rx_dc} != {slot_hwflag, slot_chan, slot_dir});
                    end
                end
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (enable) begin
                        state_n = LOAD;
                    end else begin
                        primed_n = 1'b0;
                        state_n  = IDLE;
                    end
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_isolator_link_master.sv
// Bench for isolator_link_master with SCLK_DIV = 4 (73-cycle frames).
// A board-side shift-register model sits on the serial pins. Expected
// latched bytes and expected status are queued when a run is started and
// checked as srclk strobes and frame_done pulses appear.

module tb_isolator_link_master;

    localparam int DIV       = 4;
    localparam int FRAME_LEN = 1 + 18 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] cs_n_par = 4'hF;
    logic [3:0] hwcon_par = 4'h0;
    logic       dirchan = 1'b0;
    logic       hwflag = 1'b0;
    logic       sclk, srclk, cs_n, hwcon;
    logic [3:0] slot_dir, slot_chan, slot_hwflag;
    logic       status_valid, frame_done, status_changed;
    logic [2:0] fsm_state;

    isolator_link_master #(.SCLK_DIV(DIV)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .cs_n_par       (cs_n_par),
        .hwcon_par      (hwcon_par),
        .sclk           (sclk),
        .srclk          (srclk),
        .cs_n           (cs_n),
        .hwcon          (hwcon),
        .dirchan        (dirchan),
        .hwflag         (hwflag),
        .slot_dir       (slot_dir),
        .slot_chan      (slot_chan),
        .slot_hwflag    (slot_hwflag),
        .status_valid   (status_valid),
        .frame_done     (frame_done),
        .status_changed (status_changed),
        .fsm_state      (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters and check ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- board model ----------------
    logic [3:0] b_dir = 4'h0, b_chan = 4'h0, b_hf = 4'h0;
    logic [7:0] cs_sr = 8'h00, hw_sr = 8'h00;
    logic [7:0] lat_cs = 8'h00, lat_hw = 8'h00;
    logic [7:0] snap_dc = 8'h00, snap_hf = 8'h00;
    int         k_bit = 0;

    always @(posedge sclk) begin
        cs_sr = {cs_sr[6:0], cs_n};
        hw_sr = {hw_sr[6:0], hwcon};
        if (k_bit < 8) begin
            dirchan = snap_dc[3'(7 - k_bit)];
            hwflag  = snap_hf[3'(7 - k_bit)];
        end
        k_bit++;
    end

    always @(posedge srclk) begin
        lat_cs  = cs_sr;
        lat_hw  = hw_sr;
        snap_dc = {b_chan, b_dir};
        snap_hf = {4'h0, b_hf};
        k_bit   = 0;
    end

    // ---------------- scoreboard ----------------
    logic [15:0] tx_q[$];   // {latched cs_n byte, latched hwcon byte}
    logic [14:0] st_q[$];   // {consecutive, valid, changed, hwflag, chan, dir}

    int cyc = 0, last_fd = 0;
    int rise_cnt = 0, rise_total = 0, srclk_cnt = 0, fd_cnt = 0;
    logic sclk_p = 1'b0, srclk_p = 1'b0;

    always @(posedge clk) begin
        logic [15:0] e;
        logic [14:0] s;
        #1;
        cyc++;
        if (reset) begin
            sclk_p  = 1'b0;
            srclk_p = 1'b0;
        end else begin
            if (sclk && !sclk_p) begin
                rise_cnt++;
                rise_total++;
            end
            if (srclk && !srclk_p) begin
                srclk_cnt++;
                check("srclk_expected", 32'(tx_q.size() > 0), 32'd1);
                if (tx_q.size() > 0) begin
                    e = tx_q.pop_front();
                    check("latched_cs_n", 32'(lat_cs), 32'(e[15:8]));
                    check("latched_hwcon", 32'(lat_hw), 32'(e[7:0]));
                    check("sclk_rises", 32'(rise_cnt), 32'd8);
                end
                rise_cnt = 0;
            end
            if (frame_done) begin
                fd_cnt++;
                check("frame_done_expected", 32'(st_q.size() > 0), 32'd1);
                if (st_q.size() > 0) begin
                    s = st_q.pop_front();
                    check("status_valid", 32'(status_valid), 32'(s[13]));
                    check("status_changed", 32'(status_changed), 32'(s[12]));
                    check("slot_hwflag", 32'(slot_hwflag), 32'(s[11:8]));
                    check("slot_chan", 32'(slot_chan), 32'(s[7:4]));
                    check("slot_dir", 32'(slot_dir), 32'(s[3:0]));
                    if (s[14]) check("frame_len", 32'(cyc - last_fd), 32'(FRAME_LEN));
                end
                last_fd = cyc;
            end
            check("changed_without_done", 32'(status_changed & ~frame_done), 32'd0);
            sclk_p  = sclk;
            srclk_p = srclk;
        end
    end

    // ---------------- reference status model ----------------
    logic       m_valid = 1'b0;
    logic [3:0] m_dir = 4'h0, m_chan = 4'h0, m_hf = 4'h0;

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs();
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_srclk", 32'(srclk), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_hwcon", 32'(hwcon), 32'd0);
        check("rst_slots", 32'({slot_hwflag, slot_chan, slot_dir}), 32'd0);
        check("rst_valid", 32'(status_valid), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_changed", 32'(status_changed), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
    endtask

    // Runs n frames. Frame 1 transmits cs_a/hw_a; the pars switch to
    // cs_b/hw_b at the first sclk rise (after LOAD), so frames 2..n send
    // cs_b/hw_b. Board hwflag switches to hf1 after frame chg_at completes.
    // With early set, enable drops about 10 cycles into frame 1's SHIFT.
    task automatic run_frames(input int n, input logic [3:0] cs_a, input logic [3:0] hw_a,
                              input logic [3:0] cs_b, input logic [3:0] hw_b,
                              input logic [3:0] dir, input logic [3:0] chan,
                              input logic [3:0] hf0, input int chg_at,
                              input logic [3:0] hf1, input bit early);
        int base_fd, base_sr, base_rise, budget;
        bit par_done, hf_done;
        logic [3:0] nh, ec, eh;
        bit con, chg;
        cs_n_par  = cs_a;
        hwcon_par = hw_a;
        b_dir     = dir;
        b_chan    = chan;
        b_hf      = hf0;
        for (int k = 1; k <= n; k++) begin
            ec = (k == 1) ? cs_a : cs_b;
            eh = (k == 1) ? hw_a : hw_b;
            tx_q.push_back({4'hF, ec, 4'h0, eh});
            con = 1'b0;
            chg = 1'b0;
            if (k > 1) begin
                // Frame k carries the snapshot from frame k-1's srclk.
                nh      = (k - 1 > chg_at) ? hf1 : hf0;
                con     = 1'b1;
                chg     = m_valid && ({nh, chan, dir} != {m_hf, m_chan, m_dir});
                m_hf    = nh;
                m_chan  = chan;
                m_dir   = dir;
                m_valid = 1'b1;
            end
            st_q.push_back({con, m_valid, chg, m_hf, m_chan, m_dir});
        end
        base_fd   = fd_cnt;
        base_sr   = srclk_cnt;
        base_rise = rise_total;
        par_done  = 1'b0;
        hf_done   = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        budget = n * FRAME_LEN + 100;
        while (budget > 0 && fd_cnt - base_fd < n) begin
            @(negedge clk);
            budget--;
            if (!par_done && rise_total > base_rise) begin
                par_done  = 1'b1;
                cs_n_par  = cs_b;
                hwcon_par = hw_b;
                if (early) begin
                    repeat (6) @(negedge clk);
                    budget -= 6;
                    enable = 1'b0;
                end
            end
            if (!hf_done && fd_cnt - base_fd == chg_at) begin
                hf_done = 1'b1;
                b_hf    = hf1;
            end
            if (!early && enable && srclk_cnt - base_sr >= n) enable = 1'b0;
        end
        check("frames_completed", 32'(fd_cnt - base_fd), 32'(n));
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_state", 32'(fsm_state), 32'd0);
        check("idle_pins", 32'({sclk, srclk, cs_n}), 32'b001);
        check("queues_drained", 32'(tx_q.size() + st_q.size()), 32'd0);
        tx_q.delete();
        st_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base, budget;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        // Idle with enable low: no activity at all.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            check("idle_pins_500", 32'({sclk, srclk, cs_n}), 32'b001);
        end

        // First run: cs_n=FE, hwcon=05; board dir=3 chan=A hwflag=9.
        run_frames(3, 4'b1110, 4'b0101, 4'b1110, 4'b0101,
                   4'b0011, 4'b1010, 4'b1001, 99, 4'b1001, 1'b0);

        // Pars change after LOAD of frame 1; hwflag 9->1 after frame 1.
        run_frames(4, 4'b1110, 4'b0101, 4'b0011, 4'b1010,
                   4'b0011, 4'b1010, 4'b1001, 1, 4'b0001, 1'b0);

        // Enable dropped early in SHIFT: the frame still completes.
        run_frames(1, 4'b1010, 4'b1100, 4'b1010, 4'b1100,
                   4'b0011, 4'b1010, 4'b0001, 99, 4'b0001, 1'b1);

        // Reset about 20 cycles into SHIFT.
        cs_n_par  = 4'b0110;
        hwcon_par = 4'b1001;
        base      = rise_total;
        @(negedge clk);
        enable = 1'b1;
        budget = 200;
        while (budget > 0 && rise_total == base) begin
            @(negedge clk);
            budget--;
        end
        check("first_rise_seen", 32'(rise_total > base), 32'd1);
        repeat (16) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs();
        enable   = 1'b0;
        m_valid  = 1'b0;
        m_dir    = 4'h0;
        m_chan   = 4'h0;
        m_hf     = 4'h0;
        rise_cnt = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Clean frames after reset release.
        run_frames(2, 4'b0000, 4'b1111, 4'b0000, 4'b1111,
                   4'b1100, 4'b0101, 4'b0110, 99, 4'b0110, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
